// File: rtl/daq_link_rx_deframer.sv
// DAQ link receive deframer: locks onto a clean 8b/10b word stream, strips
// SOF/EOF framing, packs 16-bit lanes into 64-bit event words and emits them
// one word late so the final word can be flagged as the trailer.
module daq_link_rx_deframer #(
    parameter int          LOCK_COUNT      = 64,
    parameter logic [15:0] MAX_EVENT_WORDS = 16'd4096
) (
    input  logic        usr_clk,
    input  logic        reset,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_charisk,
    input  logic [1:0]  rx_notintable,
    output logic [63:0] ev_data,
    output logic        ev_data_valid,
    output logic        ev_data_header,
    output logic        ev_data_trailer,
    output logic        link_up,
    output logic        frame_err,
    output logic        len_err,
    output logic [31:0] event_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [15:0] K_IDLE = 16'hDCFB;
    localparam logic [15:0] K_SOF  = 16'h5CBC;
    localparam logic [15:0] K_EOF  = 16'hFDBC;
    localparam int          LOCK_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        LINK_DOWN,
        IDLE,
        IN_FRAME,
        DISCARD
    } state_t;

    state_t            state_q;
    logic [LOCK_W-1:0] lockCnt_q;
    logic [1:0]        laneIdx_q;
    logic [15:0]       wordCnt_q;
    logic [47:0]       asm_q;
    logic [63:0]       holdWord_q;
    logic              holdValid_q;
    logic              holdFirst_q;

    logic [63:0]       evData_q;
    logic              evValid_q;
    logic              evHeader_q;
    logic              evTrailer_q;
    logic              linkUp_q;
    logic              frameErr_q;
    logic              lenErr_q;
    logic [31:0]       eventCnt_q;
    logic [15:0]       errCnt_q;

    logic              isIdleK;
    logic              isSof;
    logic              isEof;
    logic              isData;
    logic              isBadK;
    logic              codeErr;
    logic              wordDone;
    logic              overflow;
    logic              eofGood;
    logic              abortFrame;
    logic              frameErr_d;
    logic              lenErr_d;
    logic              errInc_d;
    logic [63:0]       newWord_d;

    // Classify the incoming character and work out this cycle's error/abort decisions
    always_comb begin
        isIdleK    = (rx_charisk == 2'b11) && (rx_data == K_IDLE);
        isSof      = (rx_charisk == 2'b11) && (rx_data == K_SOF);
        isEof      = (rx_charisk == 2'b11) && (rx_data == K_EOF);
        isData     = (rx_charisk == 2'b00);
        isBadK     = !isData && !isIdleK && !isSof && !isEof;
        codeErr    = (rx_notintable != 2'b00);
        wordDone   = (state_q == IN_FRAME) && !codeErr && isData && (laneIdx_q == 2'd3);
        overflow   = wordDone && (wordCnt_q >= MAX_EVENT_WORDS);
        eofGood    = (state_q == IN_FRAME) && !codeErr && isEof
                     && (laneIdx_q == 2'd0) && (wordCnt_q >= 16'd2);
        abortFrame = (state_q == IN_FRAME) && !codeErr
                     && ((isEof && !eofGood) || isSof || isBadK || overflow);
        frameErr_d = ((state_q == IN_FRAME) && codeErr) || abortFrame
                     || ((state_q == IDLE) && !codeErr && (isEof || isBadK));
        lenErr_d   = eofGood && (holdWord_q[55:32] != {8'd0, wordCnt_q});
        errInc_d   = codeErr || frameErr_d || lenErr_d;
        newWord_d  = {rx_data, asm_q};
    end

    // Link/frame state machine with lane packing, one-word hold stage and registered outputs
    always_ff @(posedge usr_clk) begin
        if (reset) begin
            state_q     <= LINK_DOWN;
            lockCnt_q   <= '0;
            laneIdx_q   <= 2'd0;
            wordCnt_q   <= 16'd0;
            asm_q       <= 48'd0;
            holdWord_q  <= 64'd0;
            holdValid_q <= 1'b0;
            holdFirst_q <= 1'b0;
            evData_q    <= 64'd0;
            evValid_q   <= 1'b0;
            evHeader_q  <= 1'b0;
            evTrailer_q <= 1'b0;
            linkUp_q    <= 1'b0;
            frameErr_q  <= 1'b0;
            lenErr_q    <= 1'b0;
            eventCnt_q  <= 32'd0;
            errCnt_q    <= 16'd0;
        end else begin
            evValid_q   <= 1'b0;
            evHeader_q  <= 1'b0;
            evTrailer_q <= 1'b0;
            frameErr_q  <= frameErr_d;
            lenErr_q    <= lenErr_d;
            if (errInc_d && (errCnt_q != 16'hFFFF)) begin
                errCnt_q <= errCnt_q + 16'd1;
            end

            if ((state_q != LINK_DOWN) && codeErr) begin
                // A code error anywhere after lock drops the link; any partial frame is lost.
                state_q     <= LINK_DOWN;
                linkUp_q    <= 1'b0;
                lockCnt_q   <= '0;
                holdValid_q <= 1'b0;
            end else begin
                case (state_q)
                    LINK_DOWN: begin
                        if (codeErr) begin
                            lockCnt_q <= '0;
                        end else begin
                            lockCnt_q <= lockCnt_q + LOCK_W'(1);
                            if (lockCnt_q == LOCK_W'(LOCK_COUNT - 1)) begin
                                state_q  <= IDLE;
                                linkUp_q <= 1'b1;
                            end
                        end
                    end

                    IDLE: begin
                        if (isSof) begin
                            state_q     <= IN_FRAME;
                            laneIdx_q   <= 2'd0;
                            wordCnt_q   <= 16'd0;
                            holdValid_q <= 1'b0;
                        end
                    end

                    IN_FRAME: begin
                        if (abortFrame) begin
                            // An EOF-triggered abort has already consumed the frame
                            // terminator, so there is nothing left to skip over.
                            holdValid_q <= 1'b0;
                            state_q     <= isEof ? IDLE : DISCARD;
                        end else if (eofGood) begin
                            evData_q    <= holdWord_q;
                            evValid_q   <= 1'b1;
                            evHeader_q  <= holdFirst_q;
                            evTrailer_q <= 1'b1;
                            eventCnt_q  <= eventCnt_q + 32'd1;
                            holdValid_q <= 1'b0;
                            state_q     <= IDLE;
                        end else if (isData) begin
                            if (laneIdx_q == 2'd3) begin
                                laneIdx_q   <= 2'd0;
                                wordCnt_q   <= wordCnt_q + 16'd1;
                                holdWord_q  <= newWord_d;
                                holdValid_q <= 1'b1;
                                holdFirst_q <= (wordCnt_q == 16'd0);
                                if (holdValid_q) begin
                                    evData_q   <= holdWord_q;
                                    evValid_q  <= 1'b1;
                                    evHeader_q <= holdFirst_q;
                                end
                            end else begin
                                case (laneIdx_q)
                                    2'd0:    asm_q[15:0]  <= rx_data;
                                    2'd1:    asm_q[31:16] <= rx_data;
                                    default: asm_q[47:32] <= rx_data;
                                endcase
                                laneIdx_q <= laneIdx_q + 2'd1;
                            end
                        end
                    end

                    DISCARD: begin
                        if (isSof) begin
                            state_q     <= IN_FRAME;
                            laneIdx_q   <= 2'd0;
                            wordCnt_q   <= 16'd0;
                            holdValid_q <= 1'b0;
                        end else if (isEof) begin
                            state_q <= IDLE;
                        end
                    end

                    default: begin
                        state_q <= LINK_DOWN;
                    end
                endcase
            end
        end
    end

    assign ev_data         = evData_q;
    assign ev_data_valid   = evValid_q;
    assign ev_data_header  = evHeader_q;
    assign ev_data_trailer = evTrailer_q;
    assign link_up         = linkUp_q;
    assign frame_err       = frameErr_q;
    assign len_err         = lenErr_q;
    assign event_cnt       = eventCnt_q;
    assign err_cnt         = errCnt_q;

endmodule

// File: tb/tb_daq_link_rx_deframer.sv
// Testbench for daq_link_rx_deframer: directed link/frame scenarios with a
// queue of expected event words consumed by a monitor on the falling edge.
`timescale 1ns/1ps
module tb_daq_link_rx_deframer;

    localparam logic [15:0] K_IDLE = 16'hDCFB;
    localparam logic [15:0] K_SOF  = 16'h5CBC;
    localparam logic [15:0] K_EOF  = 16'hFDBC;

    logic        usr_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] rx_data;
    logic [1:0]  rx_charisk;
    logic [1:0]  rx_notintable;
    logic [63:0] ev_data;
    logic        ev_data_valid;
    logic        ev_data_header;
    logic        ev_data_trailer;
    logic        link_up;
    logic        frame_err;
    logic        len_err;
    logic [31:0] event_cnt;
    logic [15:0] err_cnt;

    typedef struct packed {
        logic [63:0] data;
        logic        hdr;
        logic        trl;
        logic        lenErr;
    } exp_t;

    exp_t expQ[$];
    int   checks       = 0;
    int   errors       = 0;
    int   frameErrSeen = 0;
    int   expFrameErr  = 0;
    int   expEventCnt  = 0;
    int   expErrCnt    = 0;

    // 250 MHz user clock
    always #2 usr_clk = ~usr_clk;

    daq_link_rx_deframer #(
        .LOCK_COUNT(64),
        .MAX_EVENT_WORDS(16'd8)
    ) dut (
        .usr_clk(usr_clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_charisk(rx_charisk),
        .rx_notintable(rx_notintable),
        .ev_data(ev_data),
        .ev_data_valid(ev_data_valid),
        .ev_data_header(ev_data_header),
        .ev_data_trailer(ev_data_trailer),
        .link_up(link_up),
        .frame_err(frame_err),
        .len_err(len_err),
        .event_cnt(event_cnt),
        .err_cnt(err_cnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [1:0] k, input logic [1:0] nit);
        rx_data       = d;
        rx_charisk    = k;
        rx_notintable = nit;
        @(posedge usr_clk);
        #1;
    endtask

    task automatic sendIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(K_IDLE, 2'b11, 2'b00);
    endtask

    function automatic logic [63:0] mkWord(input int e, input int i, input int nWords, input int lenField);
        if (i == nWords - 1)
            return {8'hC0, lenField[23:0], 16'hE0E0, e[7:0], i[7:0]};
        return {8'hA5, e[7:0], i[15:0], 32'h1357_9BDF};
    endfunction

    task automatic sendData(input logic [63:0] w, input bit idleMid);
        for (int l = 0; l < 4; l++) begin
            if (idleMid && l == 2) applyStimulus(K_IDLE, 2'b11, 2'b00);
            applyStimulus(w[16*l +: 16], 2'b00, 2'b00);
        end
    endtask

    // Sends SOF plus nWords data words (optionally EOF); the first emitCount words are expected out
    task automatic sendFrame(input int e, input int nWords, input int lenField, input int emitCount,
                             input bit trailerOk, input int idleWord, input bit sendEof);
        logic [63:0] w;
        exp_t        rec;
        applyStimulus(K_SOF, 2'b11, 2'b00);
        for (int i = 0; i < nWords; i++) begin
            w = mkWord(e, i, nWords, lenField);
            if (i < emitCount) begin
                rec.data   = w;
                rec.hdr    = (i == 0);
                rec.trl    = trailerOk && (i == nWords - 1);
                rec.lenErr = trailerOk && (i == nWords - 1) && (lenField != nWords);
                expQ.push_back(rec);
            end
            sendData(w, i == idleWord);
        end
        if (sendEof) applyStimulus(K_EOF, 2'b11, 2'b00);
    endtask

    task automatic checkCounters(input string tag);
        sendIdle(3);
        checkOutput({tag, "_event_cnt"}, 64'(event_cnt), 64'(expEventCnt));
        checkOutput({tag, "_err_cnt"}, 64'(err_cnt), 64'(expErrCnt));
        checkOutput({tag, "_frame_err_count"}, 64'(frameErrSeen), 64'(expFrameErr));
        checkOutput({tag, "_pending_words"}, 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: pop the expected word whenever the DUT presents one
    always @(negedge usr_clk) begin
        exp_t e;
        if (frame_err) frameErrSeen++;
        if (len_err && !ev_data_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL len_err_alone: got len_err=1 with ev_data_valid=0 required len_err=0");
        end
        if (ev_data_valid) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_valid: got data=%h hdr=%b trl=%b required no output",
                         ev_data, ev_data_header, ev_data_trailer);
            end else begin
                e = expQ.pop_front();
                if ({ev_data, ev_data_header, ev_data_trailer, len_err} !== e) begin
                    errors++;
                    $display("[TB] FAIL event_word: got data=%h hdr=%b trl=%b len=%b required data=%h hdr=%b trl=%b len=%b",
                             ev_data, ev_data_header, ev_data_trailer, len_err, e.data, e.hdr, e.trl, e.lenErr);
                end
            end
        end
    end

    // Directed scenario sequence
    initial begin
        rx_data       = K_IDLE;
        rx_charisk    = 2'b11;
        rx_notintable = 2'b00;
        reset         = 1'b1;
        sendIdle(3);
        checkOutput("rst_ev_data", ev_data, 64'd0);
        checkOutput("rst_valid", 64'(ev_data_valid), 64'd0);
        checkOutput("rst_header", 64'(ev_data_header), 64'd0);
        checkOutput("rst_trailer", 64'(ev_data_trailer), 64'd0);
        checkOutput("rst_link_up", 64'(link_up), 64'd0);
        checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
        checkOutput("rst_len_err", 64'(len_err), 64'd0);
        checkOutput("rst_event_cnt", 64'(event_cnt), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
        reset = 1'b0;

        // Lock with an interruption after 63 clean cycles
        sendIdle(63);
        checkOutput("lock_first63", 64'(link_up), 64'd0);
        applyStimulus(K_IDLE, 2'b11, 2'b01);
        expErrCnt++;
        sendIdle(63);
        checkOutput("lock_after63", 64'(link_up), 64'd0);
        sendIdle(1);
        checkOutput("lock_after64", 64'(link_up), 64'd1);
        checkOutput("lock_err_cnt", 64'(err_cnt), 64'd1);

        // Good 3-word event, then the same event with an IDLE between lanes 2 and 3
        sendFrame(1, 3, 3, 3, 1, -1, 1);
        expEventCnt++;
        checkCounters("good3");
        sendFrame(1, 3, 3, 3, 1, 1, 1);
        expEventCnt++;
        checkCounters("idle_insert");

        // EOF at lane index 2 after 6 data words
        sendFrame(3, 1, 1, 0, 0, -1, 0);
        applyStimulus(16'h1111, 2'b00, 2'b00);
        applyStimulus(16'h2222, 2'b00, 2'b00);
        applyStimulus(K_EOF, 2'b11, 2'b00);
        checkOutput("eof_lane2_pulse", 64'(frame_err), 64'd1);
        expFrameErr++;
        expErrCnt++;
        sendFrame(4, 3, 3, 3, 1, -1, 1);
        expEventCnt++;
        checkCounters("eof_lane2");

        // Trailer length field 5 on a 3-word event
        sendFrame(2, 3, 5, 3, 1, -1, 1);
        expEventCnt++;
        expErrCnt++;
        checkCounters("len_mismatch");

        // Word-count limit: 9 words abort, exactly 8 words pass
        sendFrame(5, 9, 9, 7, 0, -1, 0);
        checkOutput("overflow_pulse", 64'(frame_err), 64'd1);
        expFrameErr++;
        expErrCnt++;
        applyStimulus(K_EOF, 2'b11, 2'b00);
        sendFrame(6, 8, 8, 8, 1, -1, 1);
        expEventCnt++;
        checkCounters("max_words");

        // Too-short frame, SOF inside a frame, errors while idle, partial K
        sendFrame(7, 1, 1, 0, 0, -1, 1);
        expFrameErr++;
        expErrCnt++;
        sendFrame(8, 2, 2, 1, 0, -1, 0);
        applyStimulus(K_SOF, 2'b11, 2'b00);
        expFrameErr++;
        expErrCnt++;
        applyStimulus(K_EOF, 2'b11, 2'b00);
        applyStimulus(K_EOF, 2'b11, 2'b00);
        applyStimulus(16'h1234, 2'b11, 2'b00);
        expFrameErr += 2;
        expErrCnt += 2;
        sendFrame(9, 1, 1, 0, 0, -1, 0);
        applyStimulus(16'h00BC, 2'b01, 2'b00);
        expFrameErr++;
        expErrCnt++;
        applyStimulus(K_EOF, 2'b11, 2'b00);
        checkCounters("aborts");

        // Code error mid-frame, a frame while unlocked, relock, good event
        sendFrame(10, 2, 2, 1, 0, -1, 0);
        applyStimulus(16'h5555, 2'b00, 2'b11);
        checkOutput("codeerr_frame_err", 64'(frame_err), 64'd1);
        checkOutput("codeerr_link_up", 64'(link_up), 64'd0);
        expFrameErr++;
        expErrCnt++;
        sendFrame(11, 3, 3, 0, 0, -1, 1);
        sendIdle(49);
        checkOutput("relock_63", 64'(link_up), 64'd0);
        sendIdle(1);
        checkOutput("relock_64", 64'(link_up), 64'd1);
        sendFrame(12, 3, 3, 3, 1, -1, 1);
        expEventCnt++;
        checkCounters("relock");

        // Reset in the middle of a frame
        sendFrame(13, 2, 2, 1, 0, -1, 0);
        reset = 1'b1;
        sendIdle(2);
        reset = 1'b0;
        checkOutput("midrst_valid", 64'(ev_data_valid), 64'd0);
        checkOutput("midrst_ev_data", ev_data, 64'd0);
        checkOutput("midrst_link_up", 64'(link_up), 64'd0);
        expEventCnt = 0;
        expErrCnt   = 0;
        checkCounters("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
